// File: rtl/draw_arb_pkg.sv
// Shared constants for the draw arbiter: requester indices, FSM state
// encoding and watchdog counter geometry.
// Optional feature macro used by the arbiter: DRAW_ARB_RR_EN (round-robin pick).
package draw_arb_pkg;

    localparam int unsigned NREQ_DEF = 6;
    localparam int unsigned CW_DEF   = 5;
    localparam int unsigned CMD_W    = 3;   // plot_cmd width; supports up to 8 requesters
    localparam int unsigned TMO_W    = 20;  // watchdog counter width

    localparam logic [TMO_W-1:0] TMO_MAX = '1;

    // Requester indices; index doubles as the plotter opcode.
    localparam int unsigned REQ_CLEAR   = 0;
    localparam int unsigned REQ_MAZE    = 1;
    localparam int unsigned REQ_ERASE   = 2;
    localparam int unsigned REQ_BOX     = 3;
    localparam int unsigned REQ_SPECIAL = 4;
    localparam int unsigned REQ_START   = 5;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    // Saturating watchdog increment; the count must never wrap to zero.
    function automatic logic [TMO_W-1:0] wd_step(input logic [TMO_W-1:0] c);
        return (c == TMO_MAX) ? c : c + 1'b1;
    endfunction

endpackage

// File: rtl/draw_arb_if.sv
// Draw arbiter bus: requester side (req, req_x, req_y) and plotter side
// (plot_start, plot_cmd, plot_x, plot_y, plot_done) plus owner status
// (grant, done, timeout, busy).
//   master : game logic / plotter environment driving requests and plot_done
//   slave  : the arbiter
interface draw_arb_if #(
    parameter int unsigned NREQ = draw_arb_pkg::NREQ_DEF,
    parameter int unsigned CW   = draw_arb_pkg::CW_DEF
);
    logic [NREQ-1:0]                 req;
    logic [NREQ*CW-1:0]              req_x;
    logic [NREQ*CW-1:0]              req_y;
    logic                            plot_done;
    logic                            plot_start;
    logic [draw_arb_pkg::CMD_W-1:0]  plot_cmd;
    logic [CW-1:0]                   plot_x;
    logic [CW-1:0]                   plot_y;
    logic [NREQ-1:0]                 grant;
    logic [NREQ-1:0]                 done;
    logic                            timeout;
    logic                            busy;

    modport master (
        output req, req_x, req_y, plot_done,
        input  plot_start, plot_cmd, plot_x, plot_y, grant, done, timeout, busy
    );

    modport slave (
        input  req, req_x, req_y, plot_done,
        output plot_start, plot_cmd, plot_x, plot_y, grant, done, timeout, busy
    );
endinterface

// File: rtl/draw_arb_pick.sv
// Combinational winner select for the draw arbiter.
// Ports:
//   i_req    : level requests
//   i_mask   : requests to ignore (owner that has not yet dropped its request)
//   i_ptr    : last granted index (round-robin start point)
//   o_onehot : one-hot winner, zero when nothing eligible
//   o_idx    : winner index
// DRAW_ARB_RR_EN defined: search starts at i_ptr+1 and wraps.
// DRAW_ARB_RR_EN undefined: lowest eligible index wins, i_ptr is ignored.
module draw_arb_pick
    import draw_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [NREQ-1:0]  i_mask,
    input  logic [CMD_W-1:0] i_ptr,
    output logic [NREQ-1:0]  o_onehot,
    output logic [CMD_W-1:0] o_idx
);

    logic [NREQ-1:0] w_req;
    logic            w_found;

    assign w_req = i_req & ~i_mask;

`ifdef DRAW_ARB_RR_EN
    // Two passes: indices above the pointer first, then wrap to the rest.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!w_found && w_req[i] && (i > int'(i_ptr))) begin
                w_found     = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = CMD_W'(i);
            end
        end
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!w_found && w_req[i] && (i <= int'(i_ptr))) begin
                w_found     = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = CMD_W'(i);
            end
        end
    end
`else
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;

    // Fixed priority: lowest index wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (!w_found && w_req[i]) begin
                w_found     = 1'b1;
                o_onehot[i] = 1'b1;
                o_idx       = CMD_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/draw_arbiter.sv
// Shares the single VGA cell plotter between the game-logic draw requesters.
// One request is latched at a time, one plotter command is issued, the
// arbiter waits for plot_done (or the watchdog) and pulses done[owner].
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : draw_arb_if.slave (requests, plotter command/completion, status)
// Parameters: NREQ requesters, CW coordinate width, TIMEOUT watchdog limit
// (0 disables the watchdog).
// Optional feature macro: DRAW_ARB_RR_EN selects round-robin arbitration.
module draw_arbiter
    import draw_arb_pkg::*;
#(
    parameter int unsigned NREQ    = NREQ_DEF,
    parameter int unsigned CW      = CW_DEF,
    parameter int unsigned TIMEOUT = 1048575
) (
    input logic       clock,
    input logic       reset,
    draw_arb_if.slave bus
);

    localparam logic [TMO_W-1:0] TMO_CNT = TMO_W'(TIMEOUT);
    localparam bit               WD_EN   = (TIMEOUT != 0);

    state_t            r_state;
    logic [NREQ-1:0]   r_grant;
    logic [CMD_W-1:0]  r_cmd;
    logic [CW-1:0]     r_x;
    logic [CW-1:0]     r_y;
    logic              r_start;
    logic [NREQ-1:0]   r_done;
    logic              r_tmo;
    logic              r_busy;
    logic [TMO_W-1:0]  r_cnt;
    logic [NREQ-1:0]   r_mask;

    state_t            w_state_nxt;
    logic [NREQ-1:0]   w_grant_nxt;
    logic [CMD_W-1:0]  w_cmd_nxt;
    logic [CW-1:0]     w_x_nxt;
    logic [CW-1:0]     w_y_nxt;
    logic              w_start_nxt;
    logic [NREQ-1:0]   w_done_nxt;
    logic              w_tmo_nxt;
    logic              w_busy_nxt;
    logic [TMO_W-1:0]  w_cnt_nxt;
    logic [NREQ-1:0]   w_mask_nxt;
    logic [NREQ-1:0]   w_rel_mask;

    logic [NREQ-1:0]   w_pick_oh;
    logic [CMD_W-1:0]  w_pick_idx;
    logic [CMD_W-1:0]  w_ptr;

`ifdef DRAW_ARB_RR_EN
    logic [CMD_W-1:0]  r_ptr;
    logic [CMD_W-1:0]  w_ptr_nxt;
    assign w_ptr = r_ptr;
`else
    assign w_ptr = '0;
`endif

    draw_arb_pick #(.NREQ(NREQ)) u_pick (
        .i_req    (bus.req),
        .i_mask   (r_mask),
        .i_ptr    (w_ptr),
        .o_onehot (w_pick_oh),
        .o_idx    (w_pick_idx)
    );

    // State and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_cmd   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_start <= 1'b0;
            r_done  <= '0;
            r_tmo   <= 1'b0;
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_mask  <= '0;
`ifdef DRAW_ARB_RR_EN
            r_ptr   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_cmd   <= w_cmd_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_start <= w_start_nxt;
            r_done  <= w_done_nxt;
            r_tmo   <= w_tmo_nxt;
            r_busy  <= w_busy_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mask  <= w_mask_nxt;
`ifdef DRAW_ARB_RR_EN
            r_ptr   <= w_ptr_nxt;
`endif
        end
    end

    // Next state and next output values.
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_cmd_nxt   = r_cmd;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_start_nxt = 1'b0;
        w_done_nxt  = '0;
        w_tmo_nxt   = 1'b0;
        w_cnt_nxt   = '0;
        w_rel_mask  = '0;
`ifdef DRAW_ARB_RR_EN
        w_ptr_nxt   = r_ptr;
`endif

        case (r_state)
            S_IDLE: begin
                if (|w_pick_oh) begin
                    w_grant_nxt = w_pick_oh;
                    w_cmd_nxt   = w_pick_idx;
                    // Coordinates are captured only here; later changes are ignored.
                    for (int i = 0; i < int'(NREQ); i++) begin
                        if (w_pick_oh[i]) begin
                            w_x_nxt = bus.req_x[i*CW +: CW];
                            w_y_nxt = bus.req_y[i*CW +: CW];
                        end
                    end
`ifdef DRAW_ARB_RR_EN
                    w_ptr_nxt   = w_pick_idx;
`endif
                    w_state_nxt = S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_start_nxt = 1'b1;
                w_cnt_nxt   = TMO_W'(1);
                w_state_nxt = S_WAIT;
            end

            S_WAIT: begin
                // plot_done has priority over a coincident watchdog expiry.
                if (bus.plot_done) begin
                    w_done_nxt  = r_grant;
                    w_rel_mask  = r_grant;
                    w_grant_nxt = '0;
                    w_state_nxt = S_RELEASE;
                end else if (WD_EN && (r_cnt == TMO_CNT)) begin
                    w_done_nxt  = r_grant;
                    w_tmo_nxt   = 1'b1;
                    w_rel_mask  = r_grant;
                    w_grant_nxt = '0;
                    w_state_nxt = S_RELEASE;
                end else begin
                    w_cnt_nxt   = wd_step(r_cnt);
                end
            end

            S_RELEASE: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Released owner stays masked until it drops its request.
        w_mask_nxt = (r_mask & bus.req) | w_rel_mask;
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    assign bus.plot_start = r_start;
    assign bus.plot_cmd   = r_cmd;
    assign bus.plot_x     = r_x;
    assign bus.plot_y     = r_y;
    assign bus.grant      = r_grant;
    assign bus.done       = r_done;
    assign bus.timeout    = r_tmo;
    assign bus.busy       = r_busy;

endmodule

// File: tb/tb_draw_arbiter.sv
// Scoreboard bench for draw_arbiter: stimulus pushes expected plot_start and
// done events (with their cycle stamps) into queues; a negedge monitor pops
// and compares whenever the DUT presents one.
module tb_draw_arbiter;

    localparam int unsigned NR  = 6;
    localparam int unsigned CWB = 5;
    localparam int unsigned TMO = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    draw_arb_if #(.NREQ(NR), .CW(CWB)) bus();

    draw_arbiter #(.NREQ(NR), .CW(CWB), .TIMEOUT(TMO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct { int cyc; int cmd; int x; int y; int grant; } st_exp_t;
    typedef struct { int cyc; int done; int tmo; } dn_exp_t;

    st_exp_t q_start[$];
    dn_exp_t q_done[$];
    st_exp_t e_s;
    dn_exp_t e_d;

    int tx[NR];
    int ty[NR];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare every presented output event against the queues.
    always @(negedge clock) begin
        if (bus.plot_start) begin
            if (q_start.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_plot_start actual cmd=%0d required=none (cycle %0d)", bus.plot_cmd, cyc);
            end else begin
                e_s = q_start.pop_front();
                chk("start_cycle", 32'(cyc),          32'(e_s.cyc));
                chk("plot_cmd",    32'(bus.plot_cmd), 32'(e_s.cmd));
                chk("plot_x",      32'(bus.plot_x),   32'(e_s.x));
                chk("plot_y",      32'(bus.plot_y),   32'(e_s.y));
                chk("start_grant", 32'(bus.grant),    32'(e_s.grant));
            end
        end
        if ((bus.done != '0) || bus.timeout) begin
            if (q_done.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_done actual done=%0d timeout=%0d required=none (cycle %0d)", bus.done, bus.timeout, cyc);
            end else begin
                e_d = q_done.pop_front();
                chk("done_cycle", 32'(cyc),         32'(e_d.cyc));
                chk("done_vec",   32'(bus.done),    32'(e_d.done));
                chk("timeout",    32'(bus.timeout), 32'(e_d.tmo));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic go_to(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic pulse_done();
        bus.plot_done = 1'b1;
        tick(1);
        bus.plot_done = 1'b0;
    endtask

    task automatic set_xy(input int i, input int x, input int y);
        bus.req_x[i*CWB +: CWB] = CWB'(x);
        bus.req_y[i*CWB +: CWB] = CWB'(y);
        tx[i] = x;
        ty[i] = y;
    endtask

    task automatic expect_start(input int c, input int i);
        q_start.push_back('{c, i, tx[i], ty[i], (1 << i)});
    endtask

    task automatic expect_done(input int c, input int i, input int t);
        q_done.push_back('{c, (1 << i), t});
    endtask

    int c0, s, d, s2, d1, w1, w2;

    initial begin
        bus.req       = '0;
        bus.plot_done = 1'b0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        for (int i = 0; i < int'(NR); i++) set_xy(i, 16 + i, 24 + i);

        // Reset state
        tick(3);
        chk("rst_busy",       32'(bus.busy),       32'd0);
        chk("rst_grant",      32'(bus.grant),      32'd0);
        chk("rst_done",       32'(bus.done),       32'd0);
        chk("rst_timeout",    32'(bus.timeout),    32'd0);
        chk("rst_plot_start", 32'(bus.plot_start), 32'd0);
        chk("rst_plot_cmd",   32'(bus.plot_cmd),   32'd0);
        chk("rst_plot_x",     32'(bus.plot_x),     32'd0);
        chk("rst_plot_y",     32'(bus.plot_y),     32'd0);
        reset = 1'b0;
        tick(2);
        // plot_done while idle must be ignored
        pulse_done();
        tick(2);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Single req[3], x=7 y=4; plot_done during ISSUE ignored; x/y changed mid-plot
        set_xy(3, 7, 4);
        c0 = cyc;
        bus.req[3] = 1'b1;
        s = c0 + 2;
        expect_start(s, 3);
        tick(1);
        pulse_done();
        bus.req_x[3*CWB +: CWB] = 5'd9;
        bus.req_y[3*CWB +: CWB] = 5'd1;
        d = s + 10;
        expect_done(d + 1, 3, 0);
        go_to(d);
        pulse_done();
        chk("t1_plot_x_held", 32'(bus.plot_x), 32'd7);
        chk("t1_plot_y_held", 32'(bus.plot_y), 32'd4);
        chk("t1_busy_release", 32'(bus.busy), 32'd1);
        bus.req[3] = 1'b0;
        tick(1);
        chk("t1_busy_low",  32'(bus.busy),     32'd0);
        chk("t1_grant_low", 32'(bus.grant),    32'd0);
        chk("t1_cmd_held",  32'(bus.plot_cmd), 32'd3);
        tick(1);

        // Single req[1] (leaves last grant = 1)
        set_xy(1, 11, 12);
        set_xy(3, 13, 14);
        c0 = cyc;
        bus.req[1] = 1'b1;
        s = c0 + 2;
        expect_start(s, 1);
        d = s + 1;
        expect_done(d + 1, 1, 0);
        go_to(d);
        pulse_done();
        bus.req[1] = 1'b0;
        tick(2);

        // Simultaneous req = 6'b001010
`ifdef DRAW_ARB_RR_EN
        w1 = 3; w2 = 1;
`else
        w1 = 1; w2 = 3;
`endif
        c0 = cyc;
        bus.req = 6'b001010;
        s = c0 + 2;
        expect_start(s, w1);
        d1 = s + 2;
        expect_done(d1 + 1, w1, 0);
        s2 = d1 + 4;
        expect_start(s2, w2);
        go_to(d1);
        pulse_done();
        bus.req[w1] = 1'b0;
        d = s2 + 2;
        expect_done(d + 1, w2, 0);
        go_to(d);
        pulse_done();
        bus.req[w2] = 1'b0;
        tick(2);

        // Owner holds req[2] 3 cycles past done: no regrant
        set_xy(2, 5, 6);
        c0 = cyc;
        bus.req[2] = 1'b1;
        s = c0 + 2;
        expect_start(s, 2);
        d = s + 3;
        expect_done(d + 1, 2, 0);
        go_to(d);
        pulse_done();
        tick(3);
        bus.req[2] = 1'b0;
        tick(6);
        chk("t3_busy_low",  32'(bus.busy),  32'd0);
        chk("t3_grant_low", 32'(bus.grant), 32'd0);

        // Watchdog: plotter silent, done+timeout on WAIT cycle TMO
        set_xy(4, 30, 31);
        c0 = cyc;
        bus.req[4] = 1'b1;
        s = c0 + 2;
        expect_start(s, 4);
        expect_done(s + int'(TMO), 4, 1);
        go_to(s + int'(TMO));
        bus.req[4] = 1'b0;
        tick(2);

        // plot_done coincident with watchdog expiry: normal completion
        set_xy(5, 1, 2);
        c0 = cyc;
        bus.req[5] = 1'b1;
        s = c0 + 2;
        expect_start(s, 5);
        expect_done(s + int'(TMO), 5, 0);
        go_to(s + int'(TMO) - 1);
        pulse_done();
        bus.req[5] = 1'b0;
        tick(2);

        // req[0] dropped during WAIT; non-owner req[5] blips meanwhile
        set_xy(0, 3, 3);
        c0 = cyc;
        bus.req[0] = 1'b1;
        s = c0 + 2;
        expect_start(s, 0);
        go_to(s + 1);
        bus.req[0] = 1'b0;
        bus.req[5] = 1'b1;
        tick(1);
        bus.req[5] = 1'b0;
        d = s + 4;
        expect_done(d + 1, 0, 0);
        go_to(d);
        pulse_done();
        tick(2);

        // Reset mid-WAIT: no done, later plot_done ignored
        set_xy(1, 8, 9);
        c0 = cyc;
        bus.req[1] = 1'b1;
        s = c0 + 2;
        expect_start(s, 1);
        go_to(s + 3);
        reset = 1'b1;
        bus.req[1] = 1'b0;
        tick(1);
        chk("t6_busy",       32'(bus.busy),       32'd0);
        chk("t6_grant",      32'(bus.grant),      32'd0);
        chk("t6_done",       32'(bus.done),       32'd0);
        chk("t6_plot_start", 32'(bus.plot_start), 32'd0);
        reset = 1'b0;
        tick(3);
        pulse_done();
        tick(3);
        chk("t6_busy_after", 32'(bus.busy), 32'd0);

        tick(2);
        chk("start_queue_drained", 32'(q_start.size()), 32'd0);
        chk("done_queue_drained",  32'(q_done.size()),  32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
